// File: rtl/fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.
// One outstanding request to instruction memory; bubbles are inserted whenever no instruction is ready.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t          state;
    state_t          next_state;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] fetched;
    logic            avail;
    logic            deliver;
    logic            capture;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pcf;
    assign pc_plus4       = pcf + XLEN'(4);

    assign avail   = ((state == WAIT) && imem_rsp_valid) || (state == HOLD);
    assign fetched = (state == HOLD) ? hold_buf : imem_rsp_data;
    assign deliver = avail && !StallF && !PCSrcE;
    // A response that lands while fetch is stalled is parked until the stall lifts.
    assign capture = (state == WAIT) && imem_rsp_valid && !PCSrcE && StallF;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    next_state = PCSrcE ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (PCSrcE)      next_state = REQ;
                    else if (StallF) next_state = HOLD;
                    else             next_state = REQ;
                end else if (PCSrcE) begin
                    next_state = DRAIN;
                end
            end
            HOLD: begin
                if (PCSrcE || !StallF) next_state = REQ;
            end
            DRAIN: begin
                if (imem_rsp_valid) next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pcf      <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state <= next_state;
            if (PCSrcE && (state != IDLE)) begin
                pcf <= PCTargetE;
            end else if (deliver) begin
                pcf <= pc_plus4;
            end
            if (capture) begin
                hold_buf <= imem_rsp_data;
            end
        end
    end

    // Flush beats stall so a squashed instruction cannot linger in decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                InstrD   <= fetched;
                PCD      <= pcf;
                PCPlus4D <= pc_plus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an architectural model of the expected fetch address stream.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int failures = 0;

    int          mem_lat = 1;
    logic        busy;
    int          cnt;
    logic [31:0] paddr;
    logic        proto_err = 1'b0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Instruction memory: a response follows each accepted request after mem_lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            cnt            <= 0;
            paddr          <= '0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && (busy || imem_rsp_valid)) proto_err <= 1'b1;
            if (busy) begin
                if (cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(paddr);
                    busy           <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_req_addr);
                end else begin
                    busy  <= 1'b1;
                    cnt   <= mem_lat - 1;
                    paddr <= imem_req_addr;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one settled step into cycle 0 (DUT in IDLE).
    task automatic start_run();
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; imem_req_ready = 1'b1; mem_lat = 1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start_run();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr, ValidD, InstrD, PCD, PCPlus4D} !==
            {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0})
            $display("FAIL reset_values: got v=%b a=%h vd=%b i=%h pcd=%h p4=%h want 0 0 0 %h 0 0",
                     imem_req_valid, imem_req_addr, ValidD, InstrD, PCD, PCPlus4D, NOP);
        if ({imem_req_valid, imem_req_addr, ValidD, InstrD, PCD, PCPlus4D} !==
            {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0}) failures++;
        rst_n = 1'b1;
        mem_lat = 3;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr, ValidD, InstrD} !== {1'b0, 32'h0, 1'b0, NOP}) begin
            failures++;
            $display("FAIL midflight_reset: got v=%b a=%h vd=%b i=%h want 0 0 0 %h",
                     imem_req_valid, imem_req_addr, ValidD, InstrD, NOP);
        end
        mem_lat = 1;
    endtask

    task automatic test_stream();
        start_run();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL stream_c0_idle: got %b want 0", imem_req_valid);
        end
        tick();
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL stream_c1_req: got %b %h want 1 0", imem_req_valid, imem_req_addr);
        end
        tick();
        checks++;
        if ({ValidD, InstrD, imem_req_valid} !== {1'b0, NOP, 1'b0}) begin
            failures++; $display("FAIL stream_c2_bubble: got %b %h %b want 0 %h 0", ValidD, InstrD, imem_req_valid, NOP);
        end
        tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0010_0093, 32'h0, 32'h4}) begin
            failures++; $display("FAIL stream_c3_first: got %b %h %h %h want 1 00100093 0 4", ValidD, InstrD, PCD, PCPlus4D);
        end
        tick();
        checks++;
        if ({ValidD, InstrD} !== {1'b0, NOP}) begin
            failures++; $display("FAIL stream_c4_bubble: got %b %h want 0 %h", ValidD, InstrD, NOP);
        end
        tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0020_0113, 32'h4, 32'h8}) begin
            failures++; $display("FAIL stream_c5_second: got %b %h %h %h want 1 00200113 4 8", ValidD, InstrD, PCD, PCPlus4D);
        end
    endtask

    task automatic test_stall_hold();
        bit found = 0;
        start_run();
        repeat (3) tick();
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ValidD, InstrD, PCD, imem_req_valid, imem_req_addr} !==
                {1'b1, 32'h0010_0093, 32'h0, 1'b0, 32'h4}) begin
                failures++;
                $display("FAIL stall_frozen[%0d]: got %b %h %h %b %h want 1 00100093 0 0 4",
                         i, ValidD, InstrD, PCD, imem_req_valid, imem_req_addr);
            end
        end
        StallF = 1'b0; StallD = 1'b0;
        tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0020_0113, 32'h4, 32'h8}) begin
            failures++; $display("FAIL stall_release: got %b %h %h %h want 1 00200113 4 8", ValidD, InstrD, PCD, PCPlus4D);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ValidD) begin
                found = 1;
                checks++;
                if (PCD !== 32'h8) begin
                    failures++; $display("FAIL stall_next_pc: got %h want 8", PCD);
                end
            end
        end
        if (!found) begin
            checks++; failures++; $display("FAIL stall_next_timeout: got none want PCD 8");
        end
    endtask

    task automatic test_redirect_drain();
        bit found = 0;
        start_run();
        mem_lat = 3;
        repeat (2) tick();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req_valid, ValidD} !== 2'b00) begin
                failures++; $display("FAIL drain_idle[%0d]: got %b %b want 0 0", i, imem_req_valid, ValidD);
            end
            tick();
        end
        mem_lat = 1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
            failures++; $display("FAIL drain_new_req: got %b %h want 1 100", imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ValidD) begin
                found = 1;
                checks++;
                if ({InstrD, PCD} !== {mem_word(32'h100), 32'h100}) begin
                    failures++; $display("FAIL drain_target: got %h %h want %h 100", InstrD, PCD, mem_word(32'h100));
                end
            end
        end
        if (!found) begin
            checks++; failures++; $display("FAIL drain_timeout: got none want PCD 100");
        end
    endtask

    task automatic test_flush_stall();
        start_run();
        repeat (3) tick();
        FlushD = 1'b1; StallD = 1'b1; StallF = 1'b1;
        tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D, imem_req_addr} !== {1'b0, NOP, 32'h0, 32'h4, 32'h4}) begin
            failures++; $display("FAIL flush_wins: got %b %h %h %h %h want 0 %h 0 4 4",
                                 ValidD, InstrD, PCD, PCPlus4D, imem_req_addr, NOP);
        end
        FlushD = 1'b0; StallD = 1'b0; StallF = 1'b0;
        tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, 32'h0020_0113, 32'h4, 32'h8}) begin
            failures++; $display("FAIL flush_resume: got %b %h %h %h want 1 00200113 4 8", ValidD, InstrD, PCD, PCPlus4D);
        end
    endtask

    task automatic test_ready_low_redirect();
        bit found = 0;
        start_run();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
                failures++; $display("FAIL ready_low[%0d]: got %b %h want 1 0", i, imem_req_valid, imem_req_addr);
            end
        end
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        tick();
        PCSrcE = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr, ValidD} !== {1'b1, 32'h40, 1'b0}) begin
            failures++; $display("FAIL ready_low_retarget: got %b %h %b want 1 40 0", imem_req_valid, imem_req_addr, ValidD);
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ValidD) begin
                found = 1;
                checks++;
                if (PCD !== 32'h40) begin
                    failures++; $display("FAIL ready_low_first_pc: got %h want 40", PCD);
                end
            end
        end
        if (!found) begin
            checks++; failures++; $display("FAIL ready_low_timeout: got none want PCD 40");
        end
    endtask

    task automatic test_wrap();
        start_run();
        imem_req_ready = 1'b0;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        imem_req_ready = 1'b1;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++; $display("FAIL wrap_req: got %b %h want 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        repeat (2) tick();
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D, imem_req_valid, imem_req_addr} !==
            {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0}) begin
            failures++; $display("FAIL wrap_deliver: got %b %h %h %h %b %h want 1 %h fffffffc 0 1 0",
                                 ValidD, InstrD, PCD, PCPlus4D, imem_req_valid, imem_req_addr, mem_word(32'hFFFF_FFFC));
        end
    endtask

    // Model: the next delivered instruction must come from model_pc, which only moves on a
    // delivery (+4) or a redirect (target); everything else must look like a bubble or a hold.
    task automatic test_random();
        logic [31:0] model_pc = '0;
        logic        p_sd = 0, p_fd = 0, p_pc = 0, p_v = 0, stall, redirect;
        logic [31:0] p_tg = '0, p_instr = NOP, p_pcd = '0, p_p4 = '0;
        int          delivered = 0;
        start_run();
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            tick();
            if (p_fd) begin
                checks++;
                if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, p_pcd, p_p4}) begin
                    failures++; $display("FAIL rnd_flush@%0d: got %b %h %h %h want 0 %h %h %h",
                                         cyc, ValidD, InstrD, PCD, PCPlus4D, NOP, p_pcd, p_p4);
                end
            end else if (p_sd) begin
                checks++;
                if ({ValidD, InstrD, PCD, PCPlus4D} !== {p_v, p_instr, p_pcd, p_p4}) begin
                    failures++; $display("FAIL rnd_stall@%0d: got %b %h %h %h want %b %h %h %h",
                                         cyc, ValidD, InstrD, PCD, PCPlus4D, p_v, p_instr, p_pcd, p_p4);
                end
            end else if (ValidD) begin
                checks++;
                if (p_pc) begin
                    failures++; $display("FAIL rnd_deliver_on_redirect@%0d: got valid PCD %h want bubble", cyc, PCD);
                end
                checks++;
                if ({InstrD, PCD, PCPlus4D} !== {mem_word(model_pc), model_pc, model_pc + 32'd4}) begin
                    failures++; $display("FAIL rnd_stream@%0d: got %h %h %h want %h %h %h",
                                         cyc, InstrD, PCD, PCPlus4D, mem_word(model_pc), model_pc, model_pc + 32'd4);
                end
                model_pc = model_pc + 32'd4;
                delivered++;
            end else begin
                checks++;
                if (InstrD !== NOP) begin
                    failures++; $display("FAIL rnd_bubble@%0d: got %h want %h", cyc, InstrD, NOP);
                end
            end
            if (p_pc) model_pc = p_tg;

            stall    = ($urandom_range(0, 5) == 0);
            redirect = (cyc >= 2) && ($urandom_range(0, 11) == 0);
            StallF = stall; StallD = stall; PCSrcE = redirect;
            PCTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            FlushD = (redirect || stall) && ($urandom_range(0, 1) == 1);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 3);
            p_sd = StallD; p_fd = FlushD; p_pc = PCSrcE; p_tg = PCTargetE;
            p_v = ValidD; p_instr = InstrD; p_pcd = PCD; p_p4 = PCPlus4D;
        end
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1;
        checks++;
        if (delivered < 100) begin
            failures++; $display("FAIL rnd_progress: got %0d deliveries want at least 100", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_drain();
        test_flush_stall();
        test_ready_low_redirect();
        test_wrap();
        test_random();
        checks++;
        if (proto_err !== 1'b0) begin
            failures++; $display("FAIL one_outstanding: got %b want 0", proto_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. It consumes the stall, flush and redirect controls that the hazard unit generates (StallF, StallD, FlushD, PCSrcE/PCTargetE). It fetches through a valid/ready request plus valid response instruction-memory port with one outstanding request. It supplies InstrD/PCD/PCPlus4D to decode and inserts NOP bubbles whenever memory has not returned an instruction.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallF  in  1  hold PCF and any returned instruction
- StallD  in  1  hold IF/ID register
- FlushD  in  1  clear IF/ID to bubble
- PCSrcE  in  1  redirect taken in execute
- PCTargetE  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  XLEN  fetch address (= PCF)
- imem_req_ready  in  1  request accepted when valid & ready
- imem_rsp_valid  in  1  response data valid (one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  XLEN  instruction word
- InstrD  out  XLEN  decode instruction
- PCD  out  XLEN  decode PC
- PCPlus4D  out  XLEN  PCD+4
- ValidD  out  1  InstrD is a real instruction

## Operation
- State register: IDLE, REQ, WAIT, HOLD, DRAIN. Hold buffer: XLEN bits.
- imem_req_valid = (state==REQ). It is registered-state driven and never depends on inputs. imem_req_addr = PCF.
- avail = (WAIT & imem_rsp_valid) | HOLD. Instruction source is imem_rsp_data in WAIT, hold buffer in HOLD.
- deliver = avail & !StallF & !PCSrcE.
- Transitions:
  - IDLE -> REQ, unconditional.
  - REQ: accepted & PCSrcE -> DRAIN. Accepted & !PCSrcE -> WAIT. Otherwise stay.
  - WAIT with rsp_valid: PCSrcE -> REQ, response dropped. StallF -> HOLD, response captured. Otherwise -> REQ, response delivered.
  - WAIT without rsp_valid: PCSrcE -> DRAIN. Otherwise stay.
  - HOLD: PCSrcE -> REQ, buffer dropped. !StallF -> REQ, buffer delivered. Otherwise stay.
  - DRAIN: rsp_valid -> REQ, response dropped. Otherwise stay.
- PCF update, in priority order:
  - PCSrcE: PCF <= PCTargetE, in any state other than IDLE.
  - deliver: PCF <= PCF+4, modulo 2^XLEN.
  - Otherwise hold.
- IF/ID update, in priority order:
  - FlushD: InstrD <= NOP, ValidD <= 0; PCD/PCPlus4D hold.
  - StallD: all hold.
  - deliver: InstrD <= instruction, PCD <= PCF, PCPlus4D <= PCF+4, ValidD <= 1.
  - Otherwise bubble: InstrD <= NOP, ValidD <= 0.
- A dropped or drained response never reaches IF/ID and never advances PCF.
- Address wrap: PCF+4 from 32'hFFFF_FFFC gives 0. No misalignment check is made.

## Timing
- Reset, asynchronous: state = IDLE, PCF = RESET_PC, imem_req_valid = 0, InstrD = NOP, PCD = 0, PCPlus4D = 0, ValidD = 0. The hold buffer is cleared.
- The first request is asserted the cycle after reset release.
- With a 1-cycle memory: request accepted in cycle n, response in cycle n+1, IF/ID valid from cycle n+2. Peak throughput is 1 instruction per 2 cycles.
- A redirect in cycle n makes a request to PCTargetE visible by cycle n+1 (REQ state) or after the outstanding response drains. The stale instruction never appears with ValidD=1.
- rst_n assertion mid-transaction abandons the outstanding request. Memory is reset in the same domain.

## Test plan
- Reset release with 1-cycle memory returning 32'h0010_0093 at 0x0 and 32'h0020_0113 at 0x4 -> req_addr 0x0 in cycle 1. InstrD=0x00100093, PCD=0, PCPlus4D=4, ValidD=1 in cycle 3. Then 0x00200113 with PCD=4 in cycle 5. ValidD=0 with InstrD=NOP in between.
- Response arrives while StallF=StallD=1 for 3 cycles -> state HOLD, IF/ID and PCF frozen. The instruction is delivered the cycle after the stall drops. No duplicate and no loss.
- PCSrcE=1 with PCTargetE=0x100 while in WAIT, response 2 cycles later -> DRAIN, response dropped. Next req_addr=0x100. First ValidD=1 has PCD=0x100.
- FlushD=1 together with StallD=1 -> ValidD=0, InstrD=NOP (flush wins). PCF behaviour is unchanged by FlushD.
- imem_req_ready low for 4 cycles, then PCSrcE to 0x40 while still unaccepted -> req_valid stays 1 and the address changes to 0x40. No instruction from the old PC is ever delivered.
- PCF=0xFFFF_FFFC delivers -> next req_addr=0x0, PCPlus4D=0x0.
